controlador_voltas: RTL and testbench
=====================================

# controlador_voltas

Lap-memory controller for the stopwatch. It sits between the button edge detectors, the BCD counter and the 4-entry lap memory. It owns the memory's single address port and sequences capture, manual recall, clear and timed auto-scan of stored laps. It also keeps occupancy state, and presents one registered lap value to the display multiplexer.

## Interface
Parameters:
- `ADDR_W`, default 2: memory address width; depth = 2**ADDR_W = 4 laps.
- `DATA_W`, default 16: lap word width (4 packed BCD digits).
- `SCAN_TICKS`, default 100: `tick_100hz` strobes per auto-scan step (100 = 1 s).

Ports:
- `CLOCK_50`, in, 1: system clock; all logic is on its rising edge.
- `KEY_RESET`, in, 1: reset, asynchronous, active-low.
- `write_req`, in, 1: one-cycle pulse; store `tempo_atual` as the next lap.
- `read_req`, in, 1: one-cycle pulse; recall the next stored lap.
- `clear_req`, in, 1: one-cycle pulse; discard all laps.
- `scan_en`, in, 1: level; when high, laps are recalled automatically.
- `tick_100hz`, in, 1: one-cycle strobe at 100 Hz, already in the `CLOCK_50` domain.
- `tempo_atual`, in, `DATA_W`: live counter value.
- `mem_rdata`, in, `DATA_W`: memory read data, one cycle after `mem_addr`.
- `mem_we`, out, 1: memory write enable; registered, one-cycle pulse.
- `mem_addr`, out, `ADDR_W`: shared read/write address; registered.
- `mem_wdata`, out, `DATA_W`: write data; registered.
- `lap_data`, out, `DATA_W`: last recalled lap; registered.
- `lap_index`, out, `ADDR_W`: address of `lap_data`.
- `lap_count`, out, `ADDR_W+1`: number of stored laps, 0..4.
- `empty`, out, 1: `lap_count == 0`.
- `full`, out, 1: `lap_count == 4`.
- `lap_valid`, out, 1: one-cycle pulse when `lap_data` updates.
- `overflow`, out, 1: one-cycle pulse when a write is dropped because the memory is full.

## Operation
- Laps occupy addresses 0..`lap_count`-1 in capture order. The write address is always `lap_count`.
- The read pointer `rd_idx` cycles 0..`lap_count`-1 and wraps to 0.
- FSM states:
  - `IDLE`: selects the highest-priority pending source.
  - `WRITE`: drives `mem_we`.
  - `RD_ADDR`: drives `mem_addr` = `rd_idx`.
  - `RD_CAP`: registers `mem_rdata`.
- Each of write, read and scan has a one-deep pending flag. The flag is set by a request while the FSM is busy, and cleared when that source is serviced. Repeated requests while pending merge into one.
- Priority in `IDLE` is clear > write > read > scan.
- Write when not full:
  - `IDLE` → `WRITE`, capturing `tempo_atual`.
  - `WRITE` drives `mem_we`=1 and `mem_addr`=`lap_count`.
  - `lap_count` increments, then → `IDLE`.
- Write when full: not performed. `overflow` pulses, and memory and count are unchanged.
- Read when not empty:
  - `IDLE` → `RD_ADDR` → `RD_CAP`.
  - `RD_CAP` loads `lap_data` ← `mem_rdata` and `lap_index` ← `rd_idx`, then sets `rd_idx` ← (`rd_idx`+1 == `lap_count`) ? 0 : `rd_idx`+1.
  - → `IDLE`.
- Read when empty: dropped, with no output change.
- Scan:
  - While `scan_en`=1 and not empty, count `tick_100hz`. On reaching `SCAN_TICKS`, reset the count and raise a scan request (serviced like a read).
  - The tick count is held at 0 while `scan_en`=0 or empty.
- Clear:
  - Accepted in any state and aborts any in-progress operation. A `mem_we` already issued is not retracted.
  - Sets `lap_count`=0, `rd_idx`=0, `lap_data`=0, `lap_index`=0, tick count=0, clears all pending flags, and → `IDLE`.
  - Memory contents are left as is; they are unreachable until rewritten.

## Timing
- Reset (`KEY_RESET`=0, asynchronous) sets:
  - state `IDLE`, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `lap_data`=0, `lap_index`=0, `lap_count`=0, `empty`=1, `full`=0;
  - `lap_valid`=0, `overflow`=0, pending flags=0, tick count=0.
- Reset mid-operation abandons the operation with no further memory write.
- Write from `IDLE`: request in cycle 0. `mem_we`=1 in cycle 1 with `mem_wdata` = `tempo_atual` of cycle 0. `lap_count`/`full` update in cycle 2. The controller is ready for a new request in cycle 2.
- Overflow: request in cycle 0, `overflow`=1 in cycle 1.
- Read from `IDLE`: request in cycle 0, `mem_addr`=`rd_idx` in cycle 1, `mem_rdata` sampled at the end of cycle 2. `lap_data`/`lap_index` change and `lap_valid`=1 in cycle 3. Ready in cycle 3.
- Clear: request in cycle 0. `lap_count`=0, `empty`=1 and `lap_data`=0 in cycle 1.
- A pending request is serviced starting the cycle after the FSM returns to `IDLE`.
- `mem_addr` holds its last value outside `WRITE`/`RD_ADDR`. `mem_we` is 0 outside `WRITE`.

## Test plan
- After reset, 4 `write_req` pulses with `tempo_atual` = 0x0112, 0x0245, 0x0378, 0x0499 → `mem_we` pulses at addresses 0,1,2,3, `lap_count`=4, `full`=1. A 5th write → `overflow` pulse, no `mem_we`.
- 5 `read_req` pulses on 3 stored laps → `lap_index` sequence 0,1,2,0,1, with `lap_data` matching the stored words and `lap_valid` 3 cycles after each request.
- `write_req` and `read_req` in the same cycle on 1 stored lap → write serviced first (`lap_count`=2). The read completes next with `lap_index`=0.
- `read_req` with `lap_count`=0 → no `mem_addr` change and no `lap_valid`. Then `clear_req` issued during `RD_ADDR` → no `lap_valid`, `lap_count`=0, `lap_data`=0 in the next cycle.
- `scan_en`=1, `SCAN_TICKS`=3, 2 laps stored, continuous ticks → one recall every 3 ticks with `lap_index` 0,1,0. Dropping `scan_en` mid-count → no further recalls, tick count restarts from 0.
- Assert `KEY_RESET` low during `WRITE` → all outputs at reset values asynchronously, and no `mem_we` after release.

Source files
------------

// File: rtl/controlador_voltas_if.sv
// rtl/controlador_voltas_if.sv - lap memory port between the lap controller (master) and the lap RAM (slave)
interface controlador_voltas_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/controlador_voltas.sv
// rtl/controlador_voltas.sv - lap memory controller: capture, recall, clear and timed auto-scan of stored laps
module controlador_voltas #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 16,
  parameter int SCAN_TICKS = 100
) (
  input  logic                CLOCK_50,
  input  logic                KEY_RESET,
  input  logic                write_req,
  input  logic                read_req,
  input  logic                clear_req,
  input  logic                scan_en,
  input  logic                tick_100hz,
  input  logic [DATA_W-1:0]   tempo_atual,
  controlador_voltas_if.master mem,
  output logic [DATA_W-1:0]   lap_data,
  output logic [ADDR_W-1:0]   lap_index,
  output logic [ADDR_W:0]     lap_count,
  output logic                empty,
  output logic                full,
  output logic                lap_valid,
  output logic                overflow
);
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam int                TICK_W    = $clog2(SCAN_TICKS) + 1;
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_CAP} state_t;

  state_t            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] lap_data_q;
  logic [ADDR_W-1:0] lap_index_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W:0]   lap_count_q;
  logic              lap_valid_q;
  logic              overflow_q;
  logic              wr_pend_q;
  logic              rd_pend_q;
  logic              scan_pend_q;
  logic [TICK_W-1:0] tick_cnt_q;

  logic              is_empty;
  logic              is_full;
  logic              scan_active;
  logic              scan_req;
  logic              wr_any;
  logic              rd_any;
  logic              scan_any;
  logic [ADDR_W-1:0] rd_idx_d;
  logic [TICK_W-1:0] tick_cnt_d;

  assign is_empty    = (lap_count_q == '0);
  assign is_full     = (lap_count_q == DEPTH_C);
  assign scan_active = scan_en && !is_empty;
  assign scan_req    = scan_active && tick_100hz && (tick_cnt_q == TICK_LAST);

  // A request that is not serviced this cycle falls through into its pending flag.
  assign wr_any   = write_req | wr_pend_q;
  assign rd_any   = read_req  | rd_pend_q;
  assign scan_any = scan_req  | scan_pend_q;

  assign rd_idx_d = (({1'b0, rd_idx_q} + 1'b1) == lap_count_q) ? '0 : rd_idx_q + 1'b1;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!scan_active) begin
      tick_cnt_d = '0;
    end else if (tick_100hz) begin
      tick_cnt_d = scan_req ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
    if (!KEY_RESET) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lap_data_q  <= '0;
      lap_index_q <= '0;
      rd_idx_q    <= '0;
      lap_count_q <= '0;
      lap_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      scan_pend_q <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      lap_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_pend_q   <= wr_any;
      rd_pend_q   <= rd_any;
      scan_pend_q <= scan_any;
      tick_cnt_q  <= tick_cnt_d;

      if (clear_req) begin
        // Memory words stay in place; dropping the count makes them unreachable.
        state_q     <= IDLE;
        lap_count_q <= '0;
        rd_idx_q    <= '0;
        lap_data_q  <= '0;
        lap_index_q <= '0;
        tick_cnt_q  <= '0;
        wr_pend_q   <= 1'b0;
        rd_pend_q   <= 1'b0;
        scan_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (wr_any) begin
              wr_pend_q <= 1'b0;
              if (is_full) begin
                overflow_q <= 1'b1;
              end else begin
                state_q     <= WRITE;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= lap_count_q[ADDR_W-1:0];
                mem_wdata_q <= tempo_atual;
              end
            end else if (rd_any) begin
              rd_pend_q <= 1'b0;
              if (!is_empty) begin
                state_q    <= RD_ADDR;
                mem_addr_q <= rd_idx_q;
              end
            end else if (scan_any) begin
              scan_pend_q <= 1'b0;
              if (!is_empty) begin
                state_q    <= RD_ADDR;
                mem_addr_q <= rd_idx_q;
              end
            end
          end
          WRITE: begin
            lap_count_q <= lap_count_q + 1'b1;
            state_q     <= IDLE;
          end
          RD_ADDR: begin
            state_q <= RD_CAP;
          end
          RD_CAP: begin
            lap_data_q  <= mem.mem_rdata;
            lap_index_q <= rd_idx_q;
            rd_idx_q    <= rd_idx_d;
            lap_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign lap_data      = lap_data_q;
  assign lap_index     = lap_index_q;
  assign lap_count     = lap_count_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign lap_valid     = lap_valid_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_controlador_voltas.sv
// tb/tb_controlador_voltas.sv - randomized scoreboard bench for the lap memory controller
module tb_controlador_voltas;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int ST = 3;

  logic          CLOCK_50 = 1'b0;
  logic          KEY_RESET = 1'b1;
  logic          write_req = 1'b0, read_req = 1'b0, clear_req = 1'b0;
  logic          scan_en = 1'b0, tick_100hz = 1'b0;
  logic [DW-1:0] tempo_atual = '0;
  logic [DW-1:0] lap_data;
  logic [AW-1:0] lap_index;
  logic [AW:0]   lap_count;
  logic          empty, full, lap_valid, overflow;

  controlador_voltas_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  controlador_voltas #(.ADDR_W(AW), .DATA_W(DW), .SCAN_TICKS(ST)) dut (
    .CLOCK_50(CLOCK_50), .KEY_RESET(KEY_RESET),
    .write_req(write_req), .read_req(read_req), .clear_req(clear_req),
    .scan_en(scan_en), .tick_100hz(tick_100hz), .tempo_atual(tempo_atual),
    .mem(mem),
    .lap_data(lap_data), .lap_index(lap_index), .lap_count(lap_count),
    .empty(empty), .full(full), .lap_valid(lap_valid), .overflow(overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Lap RAM with one cycle of read latency
  logic [DW-1:0] ram [4];
  initial foreach (ram[i]) ram[i] = '0;
  always @(posedge CLOCK_50) begin
    if (mem.mem_we) ram[mem.mem_addr] <= mem.mem_wdata;
    mem.mem_rdata <= ram[mem.mem_addr];
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } ev_t;

  ev_t we_q[$];
  ev_t lap_q[$];
  int  ov_q[$];

  // Reference model: stored laps in capture order plus a wrapping recall pointer
  logic [DW-1:0] laps[$];
  int            rdp = 0;
  int            last_addr = 0;
  int            tcnt = 0;
  logic [DW-1:0] m_data = '0;
  int            m_idx = 0;

  function automatic void model_clear();
    laps.delete();
    rdp = 0; m_data = '0; m_idx = 0; tcnt = 0;
  endfunction

  function automatic void model_write(input int t, input logic [DW-1:0] d);
    if (laps.size() < 4) begin
      we_q.push_back('{t + 1, laps.size(), d});
      last_addr = laps.size();
      laps.push_back(d);
    end else begin
      ov_q.push_back(t + 1);
    end
  endfunction

  function automatic void model_read(input int t);
    if (laps.size() > 0) begin
      lap_q.push_back('{t + 3, rdp, laps[rdp]});
      m_data = laps[rdp];
      m_idx = rdp;
      last_addr = rdp;
      rdp = (rdp + 1) % laps.size();
    end
  endfunction

  always @(negedge CLOCK_50) begin : monitor
    ev_t e;
    if (KEY_RESET) begin
      if (mem.mem_we) begin
        chk("we_expected", 32'(we_q.size() > 0), 1);
        if (we_q.size() > 0) begin
          e = we_q.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_addr", 32'(mem.mem_addr), e.idx);
          chk("we_data", 32'(mem.mem_wdata), 32'(e.data));
        end
      end
      if (lap_valid) begin
        chk("lap_valid_expected", 32'(lap_q.size() > 0), 1);
        if (lap_q.size() > 0) begin
          e = lap_q.pop_front();
          chk("lap_cycle", cyc, e.cyc);
          chk("lap_index", 32'(lap_index), e.idx);
          chk("lap_data", 32'(lap_data), 32'(e.data));
        end
      end
      if (overflow) begin
        chk("overflow_expected", 32'(ov_q.size() > 0), 1);
        if (ov_q.size() > 0) chk("overflow_cycle", cyc, ov_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    int t;
    bit was_full;
    step();
    write_req = w; read_req = r; clear_req = c; tempo_atual = d;
    t = cyc;
    if (c) begin
      model_clear();
    end else begin
      was_full = (laps.size() >= 4);
      if (w) model_write(t, d);
      if (r) model_read(!w ? t : (was_full ? t + 1 : t + 2));
    end
    step();
    write_req = 1'b0; read_req = 1'b0; clear_req = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(lap_count), laps.size());
    chk({tag, "_empty"}, 32'(empty), 32'(laps.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(laps.size() == 4));
    chk({tag, "_lap_data"}, 32'(lap_data), 32'(m_data));
    chk({tag, "_lap_index"}, 32'(lap_index), m_idx);
    chk({tag, "_mem_addr"}, 32'(mem.mem_addr), last_addr);
  endtask

  task automatic tick();
    step();
    tick_100hz = 1'b1;
    if (scan_en && laps.size() > 0) begin
      tcnt++;
      if (tcnt == ST) begin
        tcnt = 0;
        model_read(cyc);
      end
    end
    step();
    tick_100hz = 1'b0;
    settle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, 32'(mem.mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem.mem_wdata), 0);
    chk({tag, "_lap_data"}, 32'(lap_data), 0);
    chk({tag, "_lap_index"}, 32'(lap_index), 0);
    chk({tag, "_count"}, 32'(lap_count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_lap_valid"}, 32'(lap_valid), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    logic [DW-1:0] fill [4];
    int t;
    int op;
    fill[0] = 16'h0112; fill[1] = 16'h0245; fill[2] = 16'h0378; fill[3] = 16'h0499;

    #1 KEY_RESET = 1'b0;
    model_clear();
    last_addr = 0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("reset");
    KEY_RESET = 1'b1;

    // Fill to capacity, then one dropped write
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 1'b0, fill[i]);
    settle(2);
    check_state("fill");
    issue(1'b1, 1'b0, 1'b0, 16'h0555);
    settle(3);
    check_state("overflow");

    // Five recalls over three laps wrap the index
    issue(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b0, DW'($urandom));
    settle(2);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b1, 1'b0, '0);
      settle(2);
    end
    check_state("recall");

    // Simultaneous write and read: write wins, read follows
    issue(1'b0, 1'b0, 1'b1, '0);
    issue(1'b1, 1'b0, 1'b0, DW'($urandom));
    settle(2);
    issue(1'b1, 1'b1, 1'b0, DW'($urandom));
    settle(5);
    check_state("wr_rd");

    // Read on empty is dropped; clear aborts a read in flight
    issue(1'b0, 1'b0, 1'b1, '0);
    settle(1);
    issue(1'b0, 1'b1, 1'b0, '0);
    settle(4);
    check_state("empty_read");
    issue(1'b1, 1'b0, 1'b0, 16'h1234);
    issue(1'b1, 1'b0, 1'b0, 16'h5678);
    settle(2);
    issue(1'b0, 1'b1, 1'b0, '0);
    settle(3);
    step();
    read_req = 1'b1;
    last_addr = rdp;
    step();
    read_req = 1'b0;
    clear_req = 1'b1;
    model_clear();
    step();
    clear_req = 1'b0;
    chk("abort_count", 32'(lap_count), 0);
    chk("abort_empty", 32'(empty), 1);
    chk("abort_lap_data", 32'(lap_data), 0);
    settle(4);
    check_state("abort");

    // Auto-scan: one recall every ST ticks, counter restarts when scan_en drops
    issue(1'b1, 1'b0, 1'b0, DW'($urandom));
    issue(1'b1, 1'b0, 1'b0, DW'($urandom));
    settle(3);
    step();
    scan_en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    tick();
    tick();
    step();
    scan_en = 1'b0;
    tcnt = 0;
    step();
    scan_en = 1'b1;
    tick();
    tick();
    tick();
    step();
    scan_en = 1'b0;
    tcnt = 0;
    settle(3);
    check_state("scan");

    // Randomized mix of writes, reads, clears and write+read pairs
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) issue(1'b0, 1'b0, 1'b1, '0);
      else if (op <= 4) issue(1'b1, 1'b0, 1'b0, DW'($urandom));
      else if (op <= 8) issue(1'b0, 1'b1, 1'b0, '0);
      else issue(1'b1, 1'b1, 1'b0, DW'($urandom));
      settle(int'($urandom_range(5, 7)));
      check_state("rand");
    end

    // Reset while a write is on the bus
    issue(1'b0, 1'b0, 1'b1, '0);
    settle(2);
    step();
    write_req = 1'b1;
    tempo_atual = 16'hBEEF;
    t = cyc;
    step();
    write_req = 1'b0;
    #2 KEY_RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_clear();
    last_addr = 0;
    settle(2);
    KEY_RESET = 1'b1;
    settle(5);
    check_state("post_reset");
    issue(1'b1, 1'b0, 1'b0, 16'h0777);
    settle(3);
    check_state("after_reset_write");
    chk("reset_cycle_progress", 32'(cyc > t), 1);

    settle(6);
    chk("we_queue_drained", we_q.size(), 0);
    chk("lap_queue_drained", lap_q.size(), 0);
    chk("overflow_queue_drained", ov_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
